// File: rtl/adder4_ff.sv
// Registered unsigned adder: a WIDTH-bit ripple-carry sum with carry-out,
// captured in a flip-flop stage so the output is isolated from the adder chain.
module adder4_ff #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             ck,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH:0]   sum
);

  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] s;

  assign carry[0] = 1'b0;

  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    logic p;
    assign p          = a[i] ^ b[i];
    assign s[i]       = p ^ carry[i];
    assign carry[i+1] = (a[i] & b[i]) | (carry[i] & p);
  end

  // Unconditional capture every edge; reset clears asynchronously.
  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      sum <= '0;
    end else begin
      sum <= {carry[WIDTH], s};
    end
  end

endmodule

// File: tb/tb_adder4_ff.sv
// Self-checking bench for adder4_ff: directed corner cases, randomized
// back-to-back traffic and asynchronous reset, against an arithmetic model.
module tb_adder4_ff;

  localparam int unsigned WIDTH = 4;

  logic             ck;
  logic             rst_n;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH:0]   sum;

  int n_tests = 0;
  int n_fail  = 0;

  adder4_ff #(.WIDTH(WIDTH)) dut (
    .ck   (ck),
    .rst_n(rst_n),
    .a    (a),
    .b    (b),
    .sum  (sum)
  );

  initial ck = 1'b0;
  always #5 ck = ~ck;

  function automatic logic [WIDTH:0] model(input int unsigned x, input int unsigned y);
    int unsigned full;
    full = (x % (1 << WIDTH)) + (y % (1 << WIDTH));
    return (WIDTH+1)'(full);
  endfunction

  // Inputs change on the falling edge, away from the capture edge.
  task automatic drive(input int unsigned x, input int unsigned y);
    @(negedge ck);
    a = WIDTH'(x);
    b = WIDTH'(y);
  endtask

  task automatic edge_settle();
    @(posedge ck);
    #1;
  endtask

  task automatic test_reset();
    logic [WIDTH:0] exp;
    rst_n = 1'b0;
    a     = '0;
    b     = '0;
    repeat (3) @(posedge ck);
    #1;
    n_tests++;
    if (sum !== '0) begin
      n_fail++;
      $display("FAIL reset_hold: sum=%0d expected 0", sum);
    end
    // Non-zero operands must not leak through while reset is held.
    drive(5, 6);
    edge_settle();
    n_tests++;
    if (sum !== '0) begin
      n_fail++;
      $display("FAIL reset_ignores_inputs: sum=%0d expected 0", sum);
    end
    @(negedge ck);
    rst_n = 1'b1;
    a     = '0;
    b     = '0;
    exp   = model(0, 0);
    edge_settle();
    n_tests++;
    if (sum !== exp) begin
      n_fail++;
      $display("FAIL reset_release: sum=%0d expected %0d", sum, exp);
    end
  endtask

  task automatic test_directed();
    int unsigned xs[6] = '{3, 8, 9, 15, 15, 0};
    int unsigned ys[6] = '{4, 7, 11, 15, 1, 0};
    logic [WIDTH:0] prev;
    logic [WIDTH:0] exp;
    prev = model(0, 0);
    for (int i = 0; i < 6; i++) begin
      drive(xs[i], ys[i]);
      exp = model(xs[i], ys[i]);
      #1;
      n_tests++;
      if (sum !== prev) begin
        n_fail++;
        $display("FAIL directed_before_edge[%0d]: sum=%0d expected %0d", i, sum, prev);
      end
      edge_settle();
      n_tests++;
      if (sum !== exp) begin
        n_fail++;
        $display("FAIL directed_sum[%0d] %0d+%0d: sum=%0d expected %0d",
                 i, xs[i], ys[i], sum, exp);
      end
      n_tests++;
      if (sum[WIDTH] !== ((xs[i] + ys[i]) >= (1 << WIDTH))) begin
        n_fail++;
        $display("FAIL directed_carry[%0d]: carry=%0b expected %0b",
                 i, sum[WIDTH], (xs[i] + ys[i]) >= (1 << WIDTH));
      end
      prev = exp;
    end
  endtask

  task automatic test_back_to_back();
    logic [WIDTH:0] exp_q[$];
    logic [WIDTH:0] exp;
    int unsigned x;
    int unsigned y;
    for (int i = 0; i < 64; i++) begin
      x = $urandom_range((1 << WIDTH) - 1, 0);
      y = $urandom_range((1 << WIDTH) - 1, 0);
      drive(x, y);
      exp_q.push_back(model(x, y));
      edge_settle();
      exp = exp_q.pop_front();
      n_tests++;
      if (sum !== exp) begin
        n_fail++;
        $display("FAIL back_to_back[%0d] %0d+%0d: sum=%0d expected %0d", i, x, y, sum, exp);
      end
    end
  endtask

  task automatic test_mid_cycle_change();
    logic [WIDTH:0] held;
    logic [WIDTH:0] exp;
    drive(6, 2);
    edge_settle();
    held = model(6, 2);
    // Wiggle operands between edges; sum must stay put until the next edge.
    a = 4'd13;
    b = 4'd9;
    #2;
    a = 4'd10;
    b = 4'd12;
    exp = model(10, 12);
    #1;
    n_tests++;
    if (sum !== held) begin
      n_fail++;
      $display("FAIL mid_cycle_hold: sum=%0d expected %0d", sum, held);
    end
    edge_settle();
    n_tests++;
    if (sum !== exp) begin
      n_fail++;
      $display("FAIL mid_cycle_capture: sum=%0d expected %0d", sum, exp);
    end
  endtask

  task automatic test_async_reset();
    logic [WIDTH:0] exp;
    exp = model(15, 15);
    drive(15, 15);
    edge_settle();
    n_tests++;
    if (sum !== exp) begin
      n_fail++;
      $display("FAIL async_pre: sum=%0d expected %0d", sum, exp);
    end
    #1;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (sum !== '0) begin
      n_fail++;
      $display("FAIL async_assert: sum=%0d expected 0", sum);
    end
    edge_settle();
    n_tests++;
    if (sum !== '0) begin
      n_fail++;
      $display("FAIL async_held: sum=%0d expected 0", sum);
    end
    @(negedge ck);
    rst_n = 1'b1;
    #1;
    n_tests++;
    if (sum !== '0) begin
      n_fail++;
      $display("FAIL async_release_no_edge: sum=%0d expected 0", sum);
    end
    edge_settle();
    n_tests++;
    if (sum !== exp) begin
      n_fail++;
      $display("FAIL async_release: sum=%0d expected %0d", sum, exp);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_mid_cycle_change();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
